// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL reset controller: FSM state encoding and loss-counter width.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUNNING,
    FAULT
  } pll_ctrl_state_t;

  localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous level; output resets to 0.
module bit_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses <= so both flops sample pre-edge values and form a real 2-stage chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_controller.sv
// Sequences PLL reset, qualifies lock and holds sys_reset until lock is stable.
// Define PLL_RESET_CTRL_LOSS_COUNT_EN to implement the lock_lost_count register.
module pll_reset_controller
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES         = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  force_relock,
  output logic                  pll_rst,
  output logic                  sys_reset,
  output logic                  ready,
  output logic                  fault,
  output logic [LOSS_CNT_W-1:0] lock_lost_count
);

  localparam int PULSE_W  = $clog2(RST_PULSE_CYCLES) + 1;
  localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int CNT_W    = (PULSE_W > STABLE_W) ? PULSE_W : STABLE_W;
  localparam int TMO_W    = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
  localparam int RTY_W    = $clog2(MAX_RETRIES) + 1;

  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_DONE = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [TMO_W-1:0] TMO_DONE    = TMO_W'(LOCK_TIMEOUT_CYCLES);
  localparam logic [RTY_W-1:0] RTY_MAX     = RTY_W'(MAX_RETRIES);

  logic            locked_s;
  pll_ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic pll_rst_q, sys_reset_q, ready_q, fault_q;

  bit_sync u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (pll_locked),
    .q_o     (locked_s)
  );

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    rty_d   = rty_q;
    unique case (state_q)
      RESET_PLL: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        tmo_d = tmo_q + 1'b1;
        if (force_relock) begin
          state_d = RESET_PLL;
        end else if (locked_s) begin
          state_d = STABLE;
        end else if (tmo_d >= TMO_DONE) begin
          rty_d   = rty_q + 1'b1;
          state_d = (rty_d == RTY_MAX) ? FAULT : RESET_PLL;
        end
      end
      STABLE: begin
        if (force_relock) begin
          state_d = RESET_PLL;
        end else if (!locked_s) begin
          // Lock glitch: stability restarts, the attempt's timeout budget does not.
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == STABLE_DONE) begin
            state_d = RUNNING;
            rty_d   = '0;
          end
        end
      end
      RUNNING: begin
        if (!locked_s || force_relock) state_d = RESET_PLL;
      end
      FAULT: begin
        if (force_relock) begin
          state_d = RESET_PLL;
          rty_d   = '0;
        end
      end
      default: state_d = RESET_PLL;
    endcase

    if (state_d == RESET_PLL && state_q != RESET_PLL) begin
      cnt_d = '0;
      tmo_d = '0;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      tmo_q       <= '0;
      rty_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      rty_q       <= rty_d;
      pll_rst_q   <= (state_d == RESET_PLL) || (state_d == FAULT);
      sys_reset_q <= (state_d != RUNNING);
      ready_q     <= (state_d == RUNNING);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_reset = sys_reset_q;
  assign ready     = ready_q;
  assign fault     = fault_q;

`ifdef PLL_RESET_CTRL_LOSS_COUNT_EN
  logic                  loss_evt;
  logic [LOSS_CNT_W-1:0] loss_q;

  // A lock drop in RUNNING counts even when force_relock arrives in the same cycle.
  assign loss_evt = (state_q == RUNNING) && !locked_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_q <= '0;
    end else if (loss_evt && (loss_q != '1)) begin
      loss_q <= loss_q + 1'b1;
    end
  end

  assign lock_lost_count = loss_q;
`else
  assign lock_lost_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_controller.sv
// Directed bench for pll_reset_controller with short sequencing parameters.
module tb_pll_reset_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       fault;
  logic [7:0] lock_lost_count;

  int n_total  = 0;
  int n_bad    = 0;
  int exp_loss = 0;

  always #5 clk = ~clk;

  pll_reset_controller #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (50),
    .MAX_RETRIES         (2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .force_relock    (force_relock),
    .pll_rst         (pll_rst),
    .sys_reset       (sys_reset),
    .ready           (ready),
    .fault           (fault),
    .lock_lost_count (lock_lost_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int exp_cnt();
`ifdef PLL_RESET_CTRL_LOSS_COUNT_EN
    return (exp_loss > 255) ? 255 : exp_loss;
`else
    return 0;
`endif
  endfunction

  // Leaves reset_n released at a falling edge; the next rising edge is cycle 1.
  task automatic do_reset();
    @(negedge clk);
    reset_n      = 1'b0;
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    exp_loss     = 0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int k = 0;
    while (!ready && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, ready, 1);
  endtask

  task automatic check_pulse(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_hi"}, pll_rst, 1);
      tick(1);
    end
    check({tag, "_lo"}, pll_rst, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    pll_locked   = 1'b0;
    force_relock = 1'b0;

    // 1: reset values, 4-cycle pulse, release 11 cycles after lock rises
    tick(2);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_reset", sys_reset, 1);
    check("rst_ready", ready, 0);
    check("rst_fault", fault, 0);
    check("rst_count", lock_lost_count, 0);
    reset_n = 1'b1;
    check_pulse("t1_pulse");
    tick(6);
    pll_locked = 1'b1;
    for (int i = 0; i < 11; i++) begin
      check("t1_held", sys_reset, 1);
      tick(1);
    end
    check("t1_release", sys_reset, 0);
    check("t1_ready", ready, 1);
    check("t1_fault", fault, 0);
    check("t1_pll_rst", pll_rst, 0);

    // 2: one-cycle lock glitch in STABLE restarts the stable count
    do_reset();
    tick(10);
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    for (int i = 0; i < 11; i++) begin
      check("t2_held", sys_reset, 1);
      tick(1);
    end
    check("t2_release", sys_reset, 0);
    check("t2_ready", ready, 1);

    // 5: force_relock in the same cycle the synced lock drop arrives
    pll_locked = 1'b0;
    tick(2);
    check("t5_still_run", sys_reset, 0);
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    exp_loss++;
    check("t5_count", lock_lost_count, exp_cnt());
    check("t5_sys_reset", sys_reset, 1);
    check("t5_ready", ready, 0);
    check_pulse("t5_pulse");
    pll_locked = 1'b1;
    wait_ready("t5_relock", 40);
    check("t5_count_once", lock_lost_count, exp_cnt());

    // 3: lock loss in RUNNING, then saturation of the loss count
    pll_locked = 1'b0;
    tick(2);
    check("t3_run", sys_reset, 0);
    tick(1);
    check("t3_sys_reset", sys_reset, 1);
    exp_loss++;
    check("t3_count", lock_lost_count, exp_cnt());
    check_pulse("t3_pulse");
    pll_locked = 1'b1;
    wait_ready("t3_relock", 40);
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      tick(3);
      pll_locked = 1'b1;
      exp_loss++;
      check("t3_sat_count", lock_lost_count, exp_cnt());
      wait_ready("t3_sat_relock", 40);
    end
    check("t3_saturated", lock_lost_count, exp_cnt());

    // 6: asynchronous reset in the middle of STABLE
    pll_locked = 1'b0;
    tick(3);
    pll_locked = 1'b1;
    tick(7);
    check("t6_in_stable", sys_reset, 1);
    check("t6_pll_rst_pre", pll_rst, 0);
    #2;
    reset_n = 1'b0;
    #1;
    exp_loss = 0;
    check("t6_pll_rst", pll_rst, 1);
    check("t6_sys_reset", sys_reset, 1);
    check("t6_ready", ready, 0);
    check("t6_fault", fault, 0);
    check("t6_count", lock_lost_count, exp_cnt());

    // 4: no lock -> two timeouts -> FAULT; force_relock recovers and clears retries
    do_reset();
    tick(53);
    check("t4_wait1", pll_rst, 0);
    check("t4_nofault1", fault, 0);
    tick(1);
    check("t4_retry_pulse", pll_rst, 1);
    tick(3);
    check("t4_retry_pulse_end", pll_rst, 1);
    tick(1);
    check("t4_wait2", pll_rst, 0);
    tick(49);
    check("t4_nofault2", fault, 0);
    check("t4_wait2_end", pll_rst, 0);
    tick(1);
    check("t4_fault", fault, 1);
    check("t4_fault_pll_rst", pll_rst, 1);
    check("t4_fault_sys_reset", sys_reset, 1);
    check("t4_fault_ready", ready, 0);
    tick(2);
    check("t4_fault_hold", fault, 1);
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    check("t4_fault_clear", fault, 0);
    check_pulse("t4_relock_pulse");
    tick(50);
    check("t4_first_retry_no_fault", fault, 0);
    check("t4_first_retry_pulse", pll_rst, 1);
    tick(53);
    check("t4_refault_pre", fault, 0);
    tick(1);
    check("t4_refault", fault, 1);
    check("t4_count", lock_lost_count, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
